// File: rtl/barcode_ean13_renderer.sv
// EAN-13 barcode renderer: draws a 95-module symbol from a 13-digit BCD code
// into the active video stream, one pixel per cycle, with registered outputs.
module barcode_ean13_renderer #(
    parameter int unsigned H_ACTIVE     = 24,
    parameter int unsigned V_ACTIVE     = 16,
    parameter int unsigned MODULE_WIDTH = 4,
    parameter int unsigned X_OFFSET     = 8,
    parameter int unsigned Y_TOP        = 2,
    parameter int unsigned BAR_HEIGHT   = 10
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iPixelSync,
    input  logic        iPixelActive,
    input  logic [51:0] iDataCode,
    input  logic        iLoad,
    output logic        oPixelSync,
    output logic        oPixelActive,
    output logic        oPixelData,
    output logic        oVideoMarker,
    output logic        oCodeValid
);
    localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
    localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
    localparam int unsigned PX_W   = (MODULE_WIDTH > 1) ? $clog2(MODULE_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StStartGuard, StLeft, StMidGuard, StRight, StEndGuard, StDone
    } state_e;

    logic [51:0]       shadow_q, shadow_d, code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    state_e            state_q, state_d, cur_state;
    logic [PX_W-1:0]   px_q, px_d, cur_px;
    logic [2:0]        mod_q, mod_d, cur_mod, last_mod;
    logic [2:0]        dig_q, dig_d, cur_dig;
    logic              sync_q, active_q, pixel_q, pixel_d, marker_q, marker_d;
    logic              bar_line, black, guard;
    logic [6:0]        pat;
    logic [3:0]        dval;
    logic [5:0]        pmask;

    // Digit k (0..12) of the code; digit 0 sits in the top nibble.
    function automatic logic [3:0] digit_at(input logic [51:0] code, input logic [3:0] k);
        logic [51:0] s;
        s = code >> (6'd48 - {k, 2'b00});
        return s[3:0];
    endfunction

    function automatic logic all_bcd(input logic [51:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (code[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [6:0] l_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0001101;
            4'd1: return 7'b0011001;
            4'd2: return 7'b0010011;
            4'd3: return 7'b0111101;
            4'd4: return 7'b0100011;
            4'd5: return 7'b0110001;
            4'd6: return 7'b0101111;
            4'd7: return 7'b0111011;
            4'd8: return 7'b0110111;
            4'd9: return 7'b0001011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] g_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0100111;
            4'd1: return 7'b0110011;
            4'd2: return 7'b0011011;
            4'd3: return 7'b0100001;
            4'd4: return 7'b0011101;
            4'd5: return 7'b0111001;
            4'd6: return 7'b0000101;
            4'd7: return 7'b0010001;
            4'd8: return 7'b0001001;
            4'd9: return 7'b0010111;
            default: return 7'b0000000;
        endcase
    endfunction

    // One bit per left digit, first digit in bit 5; 1 selects the G set.
    function automatic logic [5:0] parity_mask(input logic [3:0] d);
        case (d)
            4'd1: return 6'b001011;
            4'd2: return 6'b001101;
            4'd3: return 6'b001110;
            4'd4: return 6'b010011;
            4'd5: return 6'b011001;
            4'd6: return 6'b011100;
            4'd7: return 6'b010101;
            4'd8: return 6'b010110;
            4'd9: return 6'b011010;
            default: return 6'b000000;
        endcase
    endfunction

    // Shadow capture and frame-code handover at frame start.
    always_comb begin
        shadow_d     = iLoad ? iDataCode : shadow_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        if (iPixelSync) begin
            code_d       = iLoad ? iDataCode : shadow_q;
            code_valid_d = all_bcd(code_d);
        end
    end

    // Column/line counters; column saturates so over-long lines never retrigger.
    always_comb begin
        col_d = '0;
        if (iPixelActive) col_d = (col_q == '1) ? col_q : col_q + 1'b1;
        line_d = line_q;
        if (iPixelSync) line_d = '0;
        else if (active_q && !iPixelActive) line_d = line_q + 1'b1;
        bar_line = code_valid_q && (line_q >= LINE_W'(Y_TOP))
                   && (line_q < LINE_W'(Y_TOP + BAR_HEIGHT));
    end

    // Symbol FSM: the start column is recognised in the same cycle it is drawn.
    always_comb begin
        cur_state = state_q;
        cur_px    = px_q;
        cur_mod   = mod_q;
        cur_dig   = dig_q;
        if (state_q == StIdle && iPixelActive && bar_line && col_q == COL_W'(X_OFFSET)) begin
            cur_state = StStartGuard;
            cur_px    = '0;
            cur_mod   = '0;
            cur_dig   = '0;
        end

        black    = 1'b0;
        guard    = 1'b0;
        pat      = '0;
        dval     = '0;
        pmask    = '0;
        last_mod = 3'd2;
        case (cur_state)
            StStartGuard, StEndGuard: begin
                guard = 1'b1;
                black = ~cur_mod[0];
            end
            StMidGuard: begin
                guard    = 1'b1;
                black    = cur_mod[0];
                last_mod = 3'd4;
            end
            StLeft: begin
                dval     = digit_at(code_q, {1'b0, cur_dig} + 4'd1);
                pmask    = parity_mask(code_q[51:48]);
                pat      = pmask[3'd5 - cur_dig] ? g_code(dval) : l_code(dval);
                black    = pat[3'd6 - cur_mod];
                last_mod = 3'd6;
            end
            StRight: begin
                dval     = digit_at(code_q, {1'b0, cur_dig} + 4'd7);
                pat      = ~l_code(dval);
                black    = pat[3'd6 - cur_mod];
                last_mod = 3'd6;
            end
            default: ;
        endcase

        state_d = cur_state;
        px_d    = cur_px;
        mod_d   = cur_mod;
        dig_d   = cur_dig;
        if (cur_state != StIdle && cur_state != StDone) begin
            if (cur_px == PX_W'(MODULE_WIDTH - 1)) begin
                px_d = '0;
                if (cur_mod == last_mod) begin
                    mod_d = '0;
                    if ((cur_state == StLeft || cur_state == StRight) && cur_dig != 3'd5) begin
                        dig_d = cur_dig + 1'b1;
                    end else begin
                        dig_d = '0;
                        case (cur_state)
                            StStartGuard: state_d = StLeft;
                            StLeft:       state_d = StMidGuard;
                            StMidGuard:   state_d = StRight;
                            StRight:      state_d = StEndGuard;
                            default:      state_d = StDone;
                        endcase
                    end
                end else begin
                    mod_d = cur_mod + 1'b1;
                end
            end else begin
                px_d = cur_px + 1'b1;
            end
        end
        if (!iPixelActive) begin
            state_d = StIdle;
            px_d    = '0;
            mod_d   = '0;
            dig_d   = '0;
        end

        pixel_d  = ~(iPixelActive & black);
        marker_d = iPixelActive & guard;
    end

    // State and registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            shadow_q     <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b1;
            col_q        <= '0;
            line_q       <= '0;
            state_q      <= StIdle;
            px_q         <= '0;
            mod_q        <= '0;
            dig_q        <= '0;
            sync_q       <= 1'b0;
            active_q     <= 1'b0;
            pixel_q      <= 1'b1;
            marker_q     <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            col_q        <= col_d;
            line_q       <= line_d;
            state_q      <= state_d;
            px_q         <= px_d;
            mod_q        <= mod_d;
            dig_q        <= dig_d;
            sync_q       <= iPixelSync;
            active_q     <= iPixelActive;
            pixel_q      <= pixel_d;
            marker_q     <= marker_d;
        end
    end

    assign oPixelSync   = sync_q;
    assign oPixelActive = active_q;
    assign oPixelData   = pixel_q;
    assign oVideoMarker = marker_q;
    assign oCodeValid   = code_valid_q;

endmodule

// File: tb/tb_barcode_ean13_renderer.sv
// Bench for barcode_ean13_renderer: a module-level symbol model predicts every
// output pixel; a vector table probes decoded digits; hand sequences cover
// mid-frame loads, load-with-sync and reset mid-line.
module tb_barcode_ean13_renderer;
    localparam int MW    = 4;
    localparam int XO    = 8;
    localparam int YT    = 2;
    localparam int BH    = 10;
    localparam int LONG  = 392;
    localparam int SHORT = 24;

    logic        iClk = 1'b0;
    logic        iRst, iPixelSync, iPixelActive, iLoad;
    logic [51:0] iDataCode;
    logic        oPixelSync, oPixelActive, oPixelData, oVideoMarker, oCodeValid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [51:0] m_shadow, m_frame;
    logic        m_valid;
    bit          mods [95];
    bit          seen [95];
    logic [6:0]  l_tab [10];
    logic [6:0]  g_tab [10];
    string       par_tab [10];

    typedef struct {
        logic [51:0] code;
        logic        valid;
        logic [6:0]  d1;
        logic [6:0]  d2;
        logic [6:0]  d7;
    } vec_t;
    vec_t vecs [6];

    barcode_ean13_renderer dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iPixelSync   (iPixelSync),
        .iPixelActive (iPixelActive),
        .iDataCode    (iDataCode),
        .iLoad        (iLoad),
        .oPixelSync   (oPixelSync),
        .oPixelActive (oPixelActive),
        .oPixelData   (oPixelData),
        .oVideoMarker (oVideoMarker),
        .oCodeValid   (oCodeValid)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_bcd(input logic [51:0] c);
        for (int i = 0; i < 13; i++) if (c[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Lay out all 95 modules (1 = black) of the current frame code.
    task automatic build_mods();
        int p;
        logic [3:0] d0, d;
        logic [6:0] pt;
        if (!m_valid) return;
        p = 0;
        mods[0] = 1; mods[1] = 0; mods[2] = 1; p = 3;
        d0 = m_frame[51:48];
        for (int i = 1; i <= 6; i++) begin
            d  = m_frame[51-4*i -: 4];
            pt = (par_tab[d0][i-1] == "G") ? g_tab[d] : l_tab[d];
            for (int j = 6; j >= 0; j--) begin mods[p] = pt[j]; p++; end
        end
        for (int j = 0; j < 5; j++) begin mods[p] = (j % 2 == 1); p++; end
        for (int i = 7; i <= 12; i++) begin
            d  = m_frame[51-4*i -: 4];
            pt = ~l_tab[d];
            for (int j = 6; j >= 0; j--) begin mods[p] = pt[j]; p++; end
        end
        mods[92] = 1; mods[93] = 0; mods[94] = 1;
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_frame  = '0;
        m_valid  = 1'b1;
        build_mods();
    endtask

    function automatic logic [6:0] slice7(input int s);
        logic [6:0] r;
        for (int j = 0; j < 7; j++) r[6-j] = seen[s+j];
        return r;
    endfunction

    // One pixel clock: predict, drive, clock, update model, compare.
    task automatic step(input logic sync, input logic act, input logic load,
                        input logic [51:0] code, input int c, input int l);
        logic exp_pix, exp_mark;
        int m;
        exp_pix  = 1'b1;
        exp_mark = 1'b0;
        m        = -1;
        if (act && c >= XO && c < XO + 95 * MW) m = (c - XO) / MW;
        if (m >= 0 && m_valid && l >= YT && l < YT + BH) begin
            exp_pix  = !mods[m];
            exp_mark = (m < 3) || (m >= 45 && m < 50) || (m >= 92);
        end
        iPixelSync   = sync;
        iPixelActive = act;
        iLoad        = load;
        iDataCode    = code;
        @(posedge iClk);
        #1;
        if (sync) begin
            m_frame = load ? code : m_shadow;
            m_valid = is_bcd(m_frame);
            build_mods();
        end
        if (load) m_shadow = code;
        check("osync", 64'(oPixelSync), 64'(sync));
        check("oactive", 64'(oPixelActive), 64'(act));
        check($sformatf("pixel c%0d l%0d", c, l), 64'(oPixelData), 64'(exp_pix));
        check($sformatf("marker c%0d l%0d", c, l), 64'(oVideoMarker), 64'(exp_mark));
        check("codevalid", 64'(oCodeValid), 64'(m_valid));
        if (m >= 0 && l == YT) seen[m] = !oPixelData;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 0, 0);
    endtask

    // Frame: sync pulse, then nlines lines of len pixels; optional load at sync
    // or at column 0 of line ld_line.
    task automatic run_frame(input int len, input int nlines, input logic ld_sync,
                             input logic [51:0] code, input int ld_line);
        for (int i = 0; i < 95; i++) seen[i] = 1;
        step(1'b1, 1'b0, ld_sync, code, 0, 0);
        blank(2);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < len; c++) step(1'b0, 1'b1, (l == ld_line && c == 0), code, c, l);
            blank(3);
        end
    endtask

    function automatic logic [51:0] rand_code();
        logic [51:0] c;
        int pos;
        for (int i = 0; i < 13; i++) c[4*i +: 4] = 4'($urandom_range(9));
        if ($urandom_range(4) == 0) begin
            pos = $urandom_range(12);
            c[4*pos +: 4] = 4'($urandom_range(15, 10));
        end
        return c;
    endfunction

    initial begin
        logic [51:0] rc;
        int          len;
        l_tab = '{7'b0001101, 7'b0011001, 7'b0010011, 7'b0111101, 7'b0100011,
                  7'b0110001, 7'b0101111, 7'b0111011, 7'b0110111, 7'b0001011};
        g_tab = '{7'b0100111, 7'b0110011, 7'b0011011, 7'b0100001, 7'b0011101,
                  7'b0111001, 7'b0000101, 7'b0010001, 7'b0001001, 7'b0010111};
        par_tab = '{"LLLLLL", "LLGLGG", "LLGGLG", "LLGGGL", "LGLLGG",
                    "LGGLLG", "LGGGLL", "LGLGLG", "LGLGGL", "LGGLGL"};
        vecs[0] = '{code: 52'h0000000000000, valid: 1'b1,
                    d1: 7'b0001101, d2: 7'b0001101, d7: 7'b1110010};
        vecs[1] = '{code: 52'h5901234123457, valid: 1'b1,
                    d1: 7'b0001011, d2: 7'b0100111, d7: 7'b1100110};
        vecs[2] = '{code: 52'h8712345678906, valid: 1'b1,
                    d1: 7'b0111011, d2: 7'b0110011, d7: 7'b1010000};
        vecs[3] = '{code: 52'h4987654321098, valid: 1'b1,
                    d1: 7'b0001011, d2: 7'b0001001, d7: 7'b1000010};
        vecs[4] = '{code: 52'h590123412345A, valid: 1'b0,
                    d1: 7'b0000000, d2: 7'b0000000, d7: 7'b0000000};
        vecs[5] = '{code: 52'hA000000000000, valid: 1'b0,
                    d1: 7'b0000000, d2: 7'b0000000, d7: 7'b0000000};

        // Reset state.
        iRst = 1'b1; iPixelSync = 0; iPixelActive = 0; iLoad = 0; iDataCode = '0;
        model_reset();
        repeat (3) @(posedge iClk);
        #1;
        check("rst pixel", 64'(oPixelData), 64'd1);
        check("rst sync", 64'(oPixelSync), 64'd0);
        check("rst active", 64'(oPixelActive), 64'd0);
        check("rst marker", 64'(oVideoMarker), 64'd0);
        check("rst valid", 64'(oCodeValid), 64'd1);
        iRst = 1'b0;

        // Frame with no load draws the all-zero code.
        run_frame(SHORT, YT + 2, 1'b0, '0, -1);
        check("zero start guard", {seen[0], seen[1], seen[2]}, 3'b101);

        // Vector table: load in blanking, then one frame up to the first bar line.
        for (int v = 0; v < 6; v++) begin
            step(1'b0, 1'b0, 1'b1, vecs[v].code, 0, 0);
            run_frame(LONG, YT + 1, 1'b0, '0, -1);
            check($sformatf("vec%0d valid", v), 64'(oCodeValid), 64'(vecs[v].valid));
            check($sformatf("vec%0d digit1", v), 64'(slice7(3)), 64'(vecs[v].d1));
            check($sformatf("vec%0d digit2", v), 64'(slice7(10)), 64'(vecs[v].d2));
            check($sformatf("vec%0d digit7", v), 64'(slice7(50)), 64'(vecs[v].d7));
        end

        // Mid-frame load waits for the next sync; load with sync applies at once.
        step(1'b0, 1'b0, 1'b1, 52'h0000000000000, 0, 0);
        run_frame(LONG, YT + 1, 1'b0, '0, -1);
        run_frame(LONG, YT + 1, 1'b0, 52'h5901234123457, 1);
        check("midload old digit1", 64'(slice7(3)), 64'(7'b0001101));
        run_frame(LONG, YT + 1, 1'b0, '0, -1);
        check("midload new digit1", 64'(slice7(3)), 64'(7'b0001011));
        run_frame(LONG, YT + 1, 1'b1, 52'h8712345678906, -1);
        check("syncload digit1", 64'(slice7(3)), 64'(7'b0111011));

        // Full short frame: bar-line limits and truncation on every line.
        run_frame(SHORT, YT + BH + 1, 1'b0, '0, -1);

        // Reset mid-line while inside the start guard.
        step(1'b1, 1'b0, 1'b0, '0, 0, 0);
        blank(2);
        for (int l = 0; l < YT; l++) begin
            for (int c = 0; c < SHORT; c++) step(1'b0, 1'b1, 1'b0, '0, c, l);
            blank(3);
        end
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, '0, c, YT);
        iRst = 1'b1;
        #1;
        check("midrst pixel", 64'(oPixelData), 64'd1);
        check("midrst marker", 64'(oVideoMarker), 64'd0);
        check("midrst active", 64'(oPixelActive), 64'd0);
        check("midrst valid", 64'(oCodeValid), 64'd1);
        iPixelActive = 1'b0;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        model_reset();
        run_frame(SHORT, YT + 2, 1'b0, '0, -1);

        // Randomised frames against the model.
        for (int k = 0; k < 8; k++) begin
            rc  = rand_code();
            len = ($urandom_range(1) == 1) ? LONG : SHORT;
            if ($urandom_range(1) == 1) begin
                run_frame(len, YT + 2, 1'b1, rc, -1);
            end else begin
                step(1'b0, 1'b0, 1'b1, rc, 0, 0);
                run_frame(len, YT + 2, 1'b0, rand_code(), $urandom_range(YT + 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
